// File: rtl/tx_huge_page_rd_req_pkg.sv
// Shared constants for the huge-page read-request generator: TLP fmt/type codes,
// byte-enable field and the request FSM encoding.
package tx_huge_page_rd_req_pkg;

    localparam logic [7:0] FMT_MRD32 = 8'h00;
    localparam logic [7:0] FMT_MRD64 = 8'h20;
    // {last BE, first BE}, all bytes enabled
    localparam logic [7:0] RD_BE     = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR1     = 3'd1,
        HDR2     = 3'd2,
        WAIT_CPL = 3'd3,
        FREE     = 3'd4
    } state_t;

endpackage

// File: rtl/tx_huge_page_rd_req.sv
// Splits two ping-pong huge pages into MRd32/MRd64 read requests on a 64-bit TRN TX
// stream, throttled by an outstanding-request counter, and releases each page when drained.
module tx_huge_page_rd_req
    import tx_huge_page_rd_req_pkg::*;
#(
    parameter int MAX_RD_QW       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        trn_clk,
    input  logic        reset,
    input  logic [63:0] huge_page_addr_1,
    input  logic [63:0] huge_page_addr_2,
    input  logic [31:0] huge_page_qwords_1,
    input  logic [31:0] huge_page_qwords_2,
    input  logic        huge_page_status_1,
    input  logic        huge_page_status_2,
    output logic        huge_page_free_1,
    output logic        huge_page_free_2,
    input  logic [15:0] cfg_completer_id,
    input  logic        rd_cpl_done,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    localparam logic [31:0] MAX_QW  = 32'(MAX_RD_QW);
    localparam logic [4:0]  MAX_OUT = 5'(MAX_OUTSTANDING);

    state_t      state, state_nxt;
    logic        page_sel;          // 0 = page 1, 1 = page 2
    logic [63:0] addr;
    logic [31:0] remaining;
    logic [4:0]  tag;
    logic [4:0]  outstanding;
    logic        load;

    logic [63:0] cur_addr;
    logic [31:0] cur_qw;
    logic        cur_status;
    logic [31:0] chunk;
    logic [9:0]  len_dw;
    logic        is64;
    logic        can_issue;
    logic        hdr2_acc;
    logic        cpl_ok;
    logic [31:0] dw0, dw1;

    assign cur_addr   = page_sel ? huge_page_addr_2   : huge_page_addr_1;
    assign cur_qw     = page_sel ? huge_page_qwords_2 : huge_page_qwords_1;
    assign cur_status = page_sel ? huge_page_status_2 : huge_page_status_1;

    assign chunk     = (remaining < MAX_QW) ? remaining : MAX_QW;
    // 512 QW -> 1024 DW, which wraps to the 0 encoding naturally
    assign len_dw    = {chunk[8:0], 1'b0};
    assign is64      = |addr[63:32];
    assign can_issue = outstanding < MAX_OUT;
    assign hdr2_acc  = (state == HDR2) && !trn_tdst_rdy_n;
    assign cpl_ok    = rd_cpl_done && (outstanding != 5'd0);

    assign dw0 = {(is64 ? FMT_MRD64 : FMT_MRD32), 8'h00, 6'b000000, len_dw};
    assign dw1 = {cfg_completer_id, 3'b000, tag, RD_BE};

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            page_sel    <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            tag         <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                addr      <= cur_addr;
                remaining <= cur_qw;
            end
            if (hdr2_acc) begin
                addr      <= addr + {29'd0, chunk, 3'b000};
                remaining <= remaining - chunk;
                tag       <= tag + 5'd1;
            end
            if (state == FREE)
                page_sel <= ~page_sel;
            // a completion landing with a new request leaves the count unchanged
            case ({hdr2_acc, cpl_ok})
                2'b10:   outstanding <= outstanding + 5'd1;
                2'b01:   outstanding <= outstanding - 5'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        load             = 1'b0;
        trn_td           = '0;
        trn_trem_n       = 8'hFF;
        trn_tsof_n       = 1'b1;
        trn_teof_n       = 1'b1;
        trn_tsrc_rdy_n   = 1'b1;
        huge_page_free_1 = 1'b0;
        huge_page_free_2 = 1'b0;
        case (state)
            IDLE: begin
                if (cur_status) begin
                    load      = 1'b1;
                    state_nxt = (cur_qw != 32'd0) ? HDR1 : FREE;
                end
            end
            HDR1: begin
                // once presented, the beat stays up: outstanding can only fall meanwhile
                if (can_issue) begin
                    trn_tsrc_rdy_n = 1'b0;
                    trn_tsof_n     = 1'b0;
                    trn_trem_n     = 8'h00;
                    trn_td         = {dw0, dw1};
                    if (!trn_tdst_rdy_n)
                        state_nxt = HDR2;
                end
            end
            HDR2: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                if (is64) begin
                    trn_td     = {addr[63:32], addr[31:2], 2'b00};
                    trn_trem_n = 8'h00;
                end else begin
                    trn_td     = {addr[31:2], 2'b00, 32'h0};
                    trn_trem_n = 8'h0F;
                end
                if (!trn_tdst_rdy_n)
                    state_nxt = (remaining == chunk) ? WAIT_CPL : HDR1;
            end
            WAIT_CPL: begin
                if (outstanding == 5'd0)
                    state_nxt = FREE;
            end
            FREE: begin
                huge_page_free_1 = ~page_sel;
                huge_page_free_2 = page_sel;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_huge_page_rd_req.sv
// Randomized scoreboard bench: each loaded page is expanded into its expected TLP beats
// and free pulse; a negedge monitor compares every accepted beat and free pulse in order.
module tb_tx_huge_page_rd_req;

    localparam int RDQ  = 16;
    localparam int MOUT = 2;

    typedef struct packed {
        logic [63:0] td;
        logic [7:0]  trem;
        logic        sof;
        logic        eof;
    } beat_t;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic [63:0] huge_page_addr_1, huge_page_addr_2;
    logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
    logic        huge_page_status_1, huge_page_status_2;
    logic        huge_page_free_1, huge_page_free_2;
    logic [15:0] cfg_completer_id;
    logic        rd_cpl_done;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    tx_huge_page_rd_req #(.MAX_RD_QW(RDQ), .MAX_OUTSTANDING(MOUT)) dut (
        .trn_clk(trn_clk), .reset(reset),
        .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
        .huge_page_qwords_1(huge_page_qwords_1), .huge_page_qwords_2(huge_page_qwords_2),
        .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
        .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
        .cfg_completer_id(cfg_completer_id), .rd_cpl_done(rd_cpl_done),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n)
    );

    always #5 trn_clk = ~trn_clk;

    beat_t exp_q[$];
    int    free_q[$];
    int    n_chk = 0, n_fail = 0;
    int    issued = 0, done_cnt = 0;
    int    m_tag = 0;
    bit    chk_en = 0, manual = 0;
    bit    busy[2];
    bit    hold_v = 0;
    beat_t hold_b;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endfunction

    // Reference: a page of qw QWORDs is cut into min(rem, RDQ) chunks, each one 2-beat TLP.
    function automatic void expect_page(input int p, input logic [63:0] base, input int qw);
        logic [63:0] a;
        int          rem, c;
        beat_t       e;
        logic [9:0]  len;
        logic [7:0]  fmt;
        logic [4:0]  t;
        a   = base;
        rem = qw;
        while (rem > 0) begin
            c   = (rem < RDQ) ? rem : RDQ;
            len = 10'((2 * c) % 1024);
            fmt = (a[63:32] != 32'h0) ? 8'h20 : 8'h00;
            t   = 5'(m_tag);
            e.td = {fmt, 8'h00, 6'h00, len, cfg_completer_id, 3'b000, t, 8'hFF};
            e.trem = 8'h00; e.sof = 1'b0; e.eof = 1'b1;
            exp_q.push_back(e);
            if (fmt == 8'h20) begin
                e.td = {a[63:32], a[31:2], 2'b00}; e.trem = 8'h00;
            end else begin
                e.td = {a[31:2], 2'b00, 32'h0}; e.trem = 8'h0F;
            end
            e.sof = 1'b1; e.eof = 1'b0;
            exp_q.push_back(e);
            m_tag = (m_tag + 1) % 32;
            a     = a + 64'(8 * c);
            rem   = rem - c;
        end
        free_q.push_back(p);
    endfunction

    // Sink readiness and completion generator
    always @(posedge trn_clk) begin
        #1;
        if (!manual) trn_tdst_rdy_n = ($urandom % 4 == 0);
        rd_cpl_done = !reset && (issued - done_cnt > 0) && ($urandom % 3 == 0);
    end

    // Monitor
    always @(negedge trn_clk) begin
        beat_t cur, e;
        int    pg;
        if (chk_en && !reset) begin
            if (hold_v) begin
                chk("hold_td", trn_td, hold_b.td);
                chk("hold_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}),
                    64'({hold_b.trem, hold_b.sof, hold_b.eof, 1'b0}));
            end
            hold_v = 0;
            if (!trn_tsrc_rdy_n) begin
                cur = '{trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
                if (!trn_tsof_n)
                    chk("outstanding_limit", 64'(issued - done_cnt < MOUT), 64'd1);
                if (!trn_tdst_rdy_n) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL beat_unexpected: got %h want none", trn_td);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_td", cur.td, e.td);
                        chk("beat_ctl", 64'({cur.trem, cur.sof, cur.eof}), 64'({e.trem, e.sof, e.eof}));
                    end
                    if (!trn_teof_n) issued++;
                end else begin
                    hold_v = 1;
                    hold_b = cur;
                end
            end
            if (huge_page_free_1 || huge_page_free_2) begin
                pg = huge_page_free_1 ? 1 : 2;
                if (huge_page_free_1 && huge_page_free_2) begin
                    n_chk++; n_fail++;
                    $display("FAIL free_both: got 11 want one-hot");
                end else if (free_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL free_unexpected: got page %0d want none", pg);
                end else begin
                    chk("free_page", 64'(pg), 64'(free_q.pop_front()));
                end
                if (pg == 1) huge_page_status_1 = 1'b0; else huge_page_status_2 = 1'b0;
                busy[pg-1] = 0;
            end
        end else begin
            hold_v = 0;
        end
        if (rd_cpl_done) done_cnt++;
    end

    task automatic load(input int p, input logic [63:0] a, input int qw);
        int t = 0;
        while (busy[p-1] && t < 5000) begin
            @(posedge trn_clk); #1;
            t++;
        end
        if (busy[p-1]) begin
            n_chk++; n_fail++;
            $display("FAIL load_timeout: got page %0d busy want free", p);
        end
        @(posedge trn_clk); #1;
        expect_page(p, a, qw);
        busy[p-1] = 1;
        if (p == 1) begin
            huge_page_addr_1 = a; huge_page_qwords_1 = 32'(qw); huge_page_status_1 = 1'b1;
        end else begin
            huge_page_addr_2 = a; huge_page_qwords_2 = 32'(qw); huge_page_status_2 = 1'b1;
        end
        repeat ($urandom % 5) @(posedge trn_clk);
    endtask

    task automatic load_rand(input int p);
        logic [31:0] hi, lo;
        int          qw;
        hi = ($urandom % 2 == 0) ? $urandom : 32'h0;
        lo = $urandom & 32'hFFFF_F000;
        qw = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 80);
        load(p, {hi, lo}, qw);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || free_q.size() != 0 || busy[0] || busy[1]) && t < 20000) begin
            @(posedge trn_clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q.size() + free_q.size()), 64'd0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        huge_page_addr_1 = '0; huge_page_addr_2 = '0;
        huge_page_qwords_1 = '0; huge_page_qwords_2 = '0;
        huge_page_status_1 = 1'b0; huge_page_status_2 = 1'b0;
        cfg_completer_id = 16'($urandom);
        rd_cpl_done = 1'b0;
        trn_tdst_rdy_n = 1'b1;
        busy[0] = 0; busy[1] = 0;
        repeat (3) @(posedge trn_clk);
        #1;
        chk("rst_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("rst_sof_eof", 64'({trn_tsof_n, trn_teof_n}), 64'b11);
        chk("rst_td", trn_td, 64'h0);
        chk("rst_trem", 64'(trn_trem_n), 64'hFF);
        chk("rst_free", 64'({huge_page_free_1, huge_page_free_2}), 64'd0);
        reset = 1'b0;
        chk_en = 1;

        // directed pages first, then random; even count leaves the pointer at page 1
        load(1, 64'h0000_0001_0000_0000, 40);
        load(2, 64'h0000_0000_0010_0000, 8);
        load(1, 64'h0000_0000_0020_0000, 0);
        load(2, 64'h0000_0002_0000_3000, 16);
        for (int k = 0; k < 18; k++) load_rand((k % 2) + 1);
        drain();

        // reset while the second header beat is on the bus
        manual = 1; chk_en = 0;
        trn_tdst_rdy_n = 1'b1;
        @(posedge trn_clk); #1;
        huge_page_addr_1 = 64'h0000_0003_0000_0000;
        huge_page_qwords_1 = 32'd16;
        huge_page_status_1 = 1'b1;
        t = 0;
        do begin
            @(negedge trn_clk);
            t++;
        end while (trn_tsrc_rdy_n && t < 100);
        chk("rstp_hdr1_sof", 64'(trn_tsof_n), 64'd0);
        @(posedge trn_clk); #1 trn_tdst_rdy_n = 1'b0;
        @(posedge trn_clk); #1 trn_tdst_rdy_n = 1'b1;
        @(negedge trn_clk);
        chk("rstp_hdr2_ctl", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}), 64'b010);
        reset = 1'b1;
        #1;
        chk("rstp_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
        chk("rstp_td", trn_td, 64'h0);
        chk("rstp_trem", 64'(trn_trem_n), 64'hFF);
        huge_page_status_1 = 1'b0;
        huge_page_status_2 = 1'b0;
        m_tag = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge trn_clk);
            chk("rstp_no_free", 64'({huge_page_free_1, huge_page_free_2}), 64'd0);
        end
        @(posedge trn_clk); #1;
        reset = 1'b0;
        manual = 0; chk_en = 1;

        // restart: page 1 first, tags from 0
        load(1, 64'h0000_0000_0040_0000, 24);
        for (int k = 1; k < 4; k++) load_rand((k % 2) + 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
